// File: rtl/ppa_pkg.sv
// ppa_pkg: topology codes and pipeline-placement helpers shared by the prefix adder
package ppa_pkg;
  localparam int PPA_RIPPLE      = 0;
  localparam int PPA_SKLANSKY    = 1;
  localparam int PPA_KOGGE_STONE = 2;
  function automatic int ppa_levels(input int width, input int topology);
    return (topology == PPA_RIPPLE) ? width : $clog2(width + 1);
  endfunction
  // prefix level after which the k-th intermediate register sits: ceil(k*levels/(stages-1))
  function automatic int ppa_stage_after(input int k, input int levels, input int stages);
    return (k * levels + stages - 2) / (stages - 1);
  endfunction
  function automatic bit ppa_reg_after(input int level, input int levels, input int stages);
    for (int k = 1; k <= stages - 2; k++)
      if (ppa_stage_after(k, levels, stages) == level) return 1'b1;
    return 1'b0;
  endfunction
endpackage

// File: rtl/ppa_prefix_level.sv
// ppa_prefix_level: one combinational row of (g,p) prefix cells; node 0 is the carry-in, node i+1 is bit i
module ppa_prefix_level
  import ppa_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TOPOLOGY = PPA_SKLANSKY,
  parameter int LEVEL    = 1
) (
  input  logic [WIDTH:0] g_i,
  input  logic [WIDTH:0] p_i,
  output logic [WIDTH:0] g_o,
  output logic [WIDTH:0] p_o
);
  localparam int D = (TOPOLOGY == PPA_KOGGE_STONE) ? (1 << (LEVEL - 1)) : 1;
  for (genvar j = 0; j <= WIDTH; j++) begin : g_node
    localparam int SRC =
      (TOPOLOGY == PPA_RIPPLE)   ? ((j == LEVEL) ? j - 1 : -1) :
      (TOPOLOGY == PPA_SKLANSKY) ? ((((j >> (LEVEL - 1)) & 1) == 1) ? ((j >> (LEVEL - 1)) << (LEVEL - 1)) - 1 : -1) :
                                   ((j >= D) ? j - D : -1);
    if (SRC >= 0) begin : g_cell
      assign g_o[j] = g_i[j] | (p_i[j] & g_i[SRC]);
      assign p_o[j] = p_i[j] & p_i[SRC];
    end else begin : g_pass
      assign g_o[j] = g_i[j];
      assign p_o[j] = p_i[j];
    end
  end
endmodule

// File: rtl/ppa_pipe_adder.sv
// ppa_pipe_adder: pipelined parallel-prefix adder sum = a+b+cin with valid/ready stream handshake
// Define PPA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module ppa_pipe_adder
  import ppa_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TOPOLOGY = PPA_SKLANSKY,
  parameter int STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PPA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int LEVELS = ppa_levels(WIDTH, TOPOLOGY);
  if (WIDTH < 2 || WIDTH > 64 || TOPOLOGY < PPA_RIPPLE || TOPOLOGY > PPA_KOGGE_STONE ||
      STAGES < 1 || STAGES > LEVELS + 1) begin : g_bad_param
    $error("ppa_pipe_adder: WIDTH, TOPOLOGY or STAGES out of range");
  end
  logic             adv;
  logic             m_valid_q;
  logic             cout_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH:0]   pre_g_d;
  logic [WIDTH:0]   pre_p_d;
  logic [WIDTH:0]   node_g [LEVELS+1];
  logic [WIDTH:0]   node_p [LEVELS+1];
  logic [WIDTH-1:0] node_x [LEVELS+1];
  logic [LEVELS:0]  node_v;
  logic [WIDTH:0]   c;
  logic             unused_p;
  assign adv     = !m_valid_q || m_ready;
  assign s_ready = adv;
  assign pre_g_d = {a & b, cin};
  assign pre_p_d = {a ^ b, 1'b0};
  if (STAGES > 1) begin : g_s0
    logic [WIDTH:0] g_q;
    logic [WIDTH:0] p_q;
    logic           v_q;
    always_ff @(posedge clk)
      if (!rst_n) v_q <= 1'b0;
      else if (adv) begin
        v_q <= s_valid;
        g_q <= pre_g_d;
        p_q <= pre_p_d;
      end
    assign node_v[0] = v_q;
    assign node_g[0] = g_q;
    assign node_p[0] = p_q;
    assign node_x[0] = p_q[WIDTH:1];
  end else begin : g_s0_wire
    assign node_v[0] = s_valid;
    assign node_g[0] = pre_g_d;
    assign node_p[0] = pre_p_d;
    assign node_x[0] = pre_p_d[WIDTH:1];
  end
  for (genvar i = 1; i <= LEVELS; i++) begin : g_lvl
    logic [WIDTH:0] g_d;
    logic [WIDTH:0] p_d;
    ppa_prefix_level #(.WIDTH(WIDTH), .TOPOLOGY(TOPOLOGY), .LEVEL(i)) u_level (
      .g_i(node_g[i-1]),
      .p_i(node_p[i-1]),
      .g_o(g_d),
      .p_o(p_d)
    );
    if (ppa_reg_after(i, LEVELS, STAGES)) begin : g_reg
      logic [WIDTH:0]   g_q;
      logic [WIDTH:0]   p_q;
      logic [WIDTH-1:0] x_q;
      logic             v_q;
      always_ff @(posedge clk)
        if (!rst_n) v_q <= 1'b0;
        else if (adv) begin
          v_q <= node_v[i-1];
          g_q <= g_d;
          p_q <= p_d;
          x_q <= node_x[i-1];
        end
      assign node_v[i] = v_q;
      assign node_g[i] = g_q;
      assign node_p[i] = p_q;
      assign node_x[i] = x_q;
    end else begin : g_wire
      assign node_v[i] = node_v[i-1];
      assign node_g[i] = g_d;
      assign node_p[i] = p_d;
      assign node_x[i] = node_x[i-1];
    end
  end
  // after the last level node i holds G[i-1:-1], i.e. the carry into bit i
  assign c        = node_g[LEVELS];
  assign unused_p = ^node_p[LEVELS];
  always_ff @(posedge clk)
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else if (adv) begin
      m_valid_q <= node_v[LEVELS];
      if (node_v[LEVELS]) begin
        sum_q  <= node_x[LEVELS] ^ c[WIDTH-1:0];
        cout_q <= c[WIDTH];
      end
    end
  assign m_valid = m_valid_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
`ifdef PPA_PIPE_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk)
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv && node_v[LEVELS]) ovf_q <= c[WIDTH-1] ^ c[WIDTH];
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ppa_pipe_adder.sv
// tb_ppa_pipe_adder: table sweep over all topologies/stage counts, handshake corner cases, random stream
module tb_ppa_pipe_adder;
  import ppa_pkg::*;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic       h_sv = 1'b0, h_mr = 1'b1, h_cin = 1'b0;
  logic       h_sr, h_mv, h_cout;
  logic [7:0] h_a = '0, h_b = '0, h_sum;
  logic        r_sv = 1'b0, r_mr = 1'b0, r_cin = 1'b0;
  logic        r_sr, r_mv, r_cout;
  logic [31:0] r_a = '0, r_b = '0, r_sum;
  logic       w_valid = 1'b0, w_cin = 1'b0;
  logic [7:0] w_a = '0, w_b = '0;
  logic [2:0][8:0]      sw_mv, sw_sr, sw_co;
  logic [2:0][8:0][7:0] sw_sum;
`ifdef PPA_PIPE_OVF_EN
  logic h_ovf, r_ovf;
  logic [2:0][8:0] sw_ov;
`endif
  ppa_pipe_adder #(.WIDTH(8), .TOPOLOGY(PPA_KOGGE_STONE), .STAGES(3)) u_hand (
    .clk(clk), .rst_n(rst_n), .s_valid(h_sv), .s_ready(h_sr), .a(h_a), .b(h_b), .cin(h_cin),
    .m_valid(h_mv), .m_ready(h_mr), .sum(h_sum), .cout(h_cout)
`ifdef PPA_PIPE_OVF_EN
    , .ovf(h_ovf)
`endif
  );
  ppa_pipe_adder #(.WIDTH(32), .TOPOLOGY(PPA_KOGGE_STONE), .STAGES(4)) u_rand (
    .clk(clk), .rst_n(rst_n), .s_valid(r_sv), .s_ready(r_sr), .a(r_a), .b(r_b), .cin(r_cin),
    .m_valid(r_mv), .m_ready(r_mr), .sum(r_sum), .cout(r_cout)
`ifdef PPA_PIPE_OVF_EN
    , .ovf(r_ovf)
`endif
  );
  for (genvar t = 0; t < 3; t++) begin : g_top
    for (genvar s = 1; s <= 9; s++) begin : g_st
      if (s <= ppa_levels(8, t) + 1) begin : g_dut
        ppa_pipe_adder #(.WIDTH(8), .TOPOLOGY(t), .STAGES(s)) u_sw (
          .clk(clk), .rst_n(rst_n), .s_valid(w_valid), .s_ready(sw_sr[t][s-1]), .a(w_a), .b(w_b),
          .cin(w_cin), .m_valid(sw_mv[t][s-1]), .m_ready(1'b1), .sum(sw_sum[t][s-1]), .cout(sw_co[t][s-1])
`ifdef PPA_PIPE_OVF_EN
          , .ovf(sw_ov[t][s-1])
`endif
        );
      end else begin : g_none
        assign sw_sr[t][s-1]  = 1'b1;
        assign sw_mv[t][s-1]  = 1'b0;
        assign sw_sum[t][s-1] = '0;
        assign sw_co[t][s-1]  = 1'b0;
`ifdef PPA_PIPE_OVF_EN
        assign sw_ov[t][s-1]  = 1'b0;
`endif
      end
    end
  end
  initial begin
    vec_t        vt[10];
    logic [33:0] q[$];
    logic [33:0] e;
    logic [32:0] full;
    int          got;
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vt[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[8] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    vt[9] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_mvalid", h_mv, 1'b0);
    chk("rst_sum", h_sum, 8'h00);
    chk("rst_cout", h_cout, 1'b0);
    chk("rst_sready", h_sr, 1'b1);
    chk("rst_rand_mvalid", r_mv, 1'b0);
`ifdef PPA_PIPE_OVF_EN
    chk("rst_ovf", h_ovf, 1'b0);
`endif
    rst_n = 1'b1;
    // every topology/stage count: one operand, result exactly STAGES-1 edges after the accept edge
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      w_valid = 1'b1; w_a = vt[i].a; w_b = vt[i].b; w_cin = vt[i].cin;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        w_valid = 1'b0; w_a = ~vt[i].a; w_b = 8'h5A; w_cin = ~vt[i].cin;
        for (int t = 0; t < 3; t++)
          for (int s = 1; s <= 9; s++)
            if (s <= ppa_levels(8, t) + 1) begin
              chk($sformatf("sweep_mvalid t%0d s%0d v%0d c%0d", t, s, i, c), sw_mv[t][s-1], c == s - 1);
              if (c == 0) chk($sformatf("sweep_sready t%0d s%0d", t, s), sw_sr[t][s-1], 1'b1);
              if (c >= s - 1) begin
                chk($sformatf("sweep_sum t%0d s%0d v%0d c%0d", t, s, i, c), sw_sum[t][s-1], vt[i].s);
                chk($sformatf("sweep_cout t%0d s%0d v%0d c%0d", t, s, i, c), sw_co[t][s-1], vt[i].co);
`ifdef PPA_PIPE_OVF_EN
                chk($sformatf("sweep_ovf t%0d s%0d v%0d c%0d", t, s, i, c), sw_ov[t][s-1], vt[i].ov);
`endif
              end
            end
      end
    end
    // backpressure with the 3-stage pipe full
    @(negedge clk); h_sv = 1'b1; h_a = 8'h10; h_b = 8'h01; #1 chk("bp_sready0", h_sr, 1'b1);
    @(negedge clk); h_a = 8'h20; h_b = 8'h02; #1 chk("bp_sready1", h_sr, 1'b1);
    @(negedge clk); h_a = 8'h30; h_b = 8'h03; #1 chk("bp_sready2", h_sr, 1'b1);
    @(negedge clk);
    chk("bp_first_valid", h_mv, 1'b1);
    chk("bp_first_sum", h_sum, 8'h11);
    h_mr = 1'b0; h_a = 8'h40; h_b = 8'h04;
    #1 chk("bp_stall_sready", h_sr, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid %0d", k), h_mv, 1'b1);
      chk($sformatf("bp_hold_sum %0d", k), h_sum, 8'h11);
      if (k < 2) chk($sformatf("bp_hold_sready %0d", k), h_sr, 1'b0);
    end
    h_mr = 1'b1; h_sv = 1'b0;
    #1 chk("bp_resume_sready", h_sr, 1'b1);
    @(negedge clk); chk("bp_second_valid", h_mv, 1'b1); chk("bp_second_sum", h_sum, 8'h22);
    @(negedge clk); chk("bp_third_valid", h_mv, 1'b1); chk("bp_third_sum", h_sum, 8'h33);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_drained_valid %0d", k), h_mv, 1'b0);
      chk($sformatf("bp_drained_sum %0d", k), h_sum, 8'h33);
    end
    // reset with two operands in flight
    @(negedge clk); h_sv = 1'b1; h_a = 8'h05; h_b = 8'h06;
    @(negedge clk); h_a = 8'h07; h_b = 8'h08;
    @(negedge clk); h_sv = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_mvalid", h_mv, 1'b0);
    chk("mrst_sum", h_sum, 8'h00);
    chk("mrst_cout", h_cout, 1'b0);
    rst_n = 1'b1;
    #1 chk("mrst_sready", h_sr, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("mrst_flushed %0d", k), h_mv, 1'b0);
    end
    // random stream on the 32-bit Kogge-Stone, 4-stage instance
    got = 0;
    for (int cyc = 0; cyc < 40000 && got < 10000; cyc++) begin
      @(negedge clk);
      r_sv  = ($urandom_range(0, 3) != 0);
      r_a   = $urandom;
      r_b   = $urandom;
      r_cin = 1'($urandom_range(0, 1));
      r_mr  = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_sready", r_sr, !r_mv || r_mr);
      if (r_sv && r_sr) begin
        full = {1'b0, r_a} + {1'b0, r_b} + {32'd0, r_cin};
        q.push_back({(r_a[31] == r_b[31]) && (full[31] != r_a[31]), full});
      end
      if (r_mv && r_mr) begin
        chk("rand_expected_pending", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("rand_sum #%0d", got), r_sum, e[31:0]);
          chk($sformatf("rand_cout #%0d", got), r_cout, e[32]);
`ifdef PPA_PIPE_OVF_EN
          chk($sformatf("rand_ovf #%0d", got), r_ovf, e[33]);
`endif
        end
        got++;
      end
    end
    chk("rand_result_count", got, 10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
